// File: rtl/jump_pkg.sv
// ----------------------------------------------------------------------------
// jump_pkg
// Shared decode constants and helpers for the jump unit:
//   - RV32I opcodes for JAL, JALR and conditional branches
//   - branch funct3 codes
//   - FSM state encoding (ST_RUN / ST_SQUASH)
//   - immediate extraction helpers (I, J and B formats, sign-extended)
// ----------------------------------------------------------------------------
package jump_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_t;

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    // J-type immediate is scrambled in the encoding; bit 0 is implicitly zero.
    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    // B-type immediate, also scrambled, bit 0 implicitly zero.
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/jump_cmp.sv
// ----------------------------------------------------------------------------
// jump_cmp
// Combinational branch comparator.
// Ports:
//   funct3  in  3   branch condition selector
//   rs1     in  32  first operand
//   rs2     in  32  second operand
//   taken   out 1   branch condition holds (010/011 are never taken)
// ----------------------------------------------------------------------------
module jump_cmp
    import jump_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        taken
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/jump_unit.sv
// ----------------------------------------------------------------------------
// jump_unit
// Resolves RV32I JAL / JALR / conditional branches for the fetched
// instruction, issues a one-cycle jump request with its target, squashes the
// FLUSH_DEPTH wrong-path cycles that follow a taken jump, and produces the
// link write-back (pc+4) for JAL/JALR. All outputs are registered.
//
// Parameters:
//   FLUSH_DEPTH   cycles squashed after a taken jump (0 = no squash)
// Ports:
//   clk            in  1   clock, rising edge
//   rst_           in  1   asynchronous active-low reset
//   inst_valid_i   in  1   inst_i / pc_i / operands valid
//   pc_i           in  32  PC of inst_i
//   inst_i         in  32  instruction word
//   rs1_data_i     in  32  rs1 operand
//   rs2_data_i     in  32  rs2 operand
//   jump_flag_o    out 1   taken-jump pulse to the PC register
//   jump_addr_o    out 32  jump target, held while jump_flag_o=0
//   squash_o       out 1   previous-cycle instruction was discarded
//   link_we_o      out 1   write link_data_o to link_rd_o
//   link_rd_o      out 5   link destination register
//   link_data_o    out 32  return address pc+4
//   misalign_o     out 1   only with JUMP_UNIT_MISALIGN_TRAP_EN: taken
//                          jump had target[1:0]!=0 and was suppressed
// Build option: `define JUMP_UNIT_MISALIGN_TRAP_EN enables the misalign trap.
// ----------------------------------------------------------------------------
module jump_unit
    import jump_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic        inst_valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        squash_o,
    output logic        link_we_o,
    output logic [4:0]  link_rd_o,
    output logic [31:0] link_data_o
`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
    ,
    output logic        misalign_o
`endif
);

    localparam int CNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        br_taken;
    logic        taken;
    logic        is_link;
    logic        issue;
    logic [31:0] target;
    logic [31:0] ret_addr;

    assign opcode   = inst_i[6:0];
    assign rd       = inst_i[11:7];
    assign ret_addr = pc_i + 32'd4;

    jump_cmp u_cmp (
        .funct3 (inst_i[14:12]),
        .rs1    (rs1_data_i),
        .rs2    (rs2_data_i),
        .taken  (br_taken)
    );

    always_comb begin
        taken   = 1'b0;
        is_link = 1'b0;
        target  = pc_i;
        case (opcode)
            OP_JAL: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = pc_i + imm_j(inst_i);
            end
            OP_JALR: begin
                taken   = 1'b1;
                is_link = 1'b1;
                target  = (rs1_data_i + imm_i(inst_i)) & ~32'd1;
            end
            OP_BRANCH: begin
                taken   = br_taken;
                target  = pc_i + imm_b(inst_i);
            end
            default: ;
        endcase
    end

`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = taken && (target[1:0] != 2'b00);
    assign issue      = taken && !misaligned;
`else
    assign issue      = taken;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state       <= ST_RUN;
            cnt         <= '0;
            jump_flag_o <= 1'b0;
            jump_addr_o <= '0;
            squash_o    <= 1'b0;
            link_we_o   <= 1'b0;
            link_rd_o   <= '0;
            link_data_o <= '0;
`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
            // Pulses default low; jump_addr/link_rd/link_data hold.
            jump_flag_o <= 1'b0;
            squash_o    <= 1'b0;
            link_we_o   <= 1'b0;
`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
            misalign_o  <= 1'b0;
`endif
            case (state)
                ST_RUN: begin
                    if (inst_valid_i && issue) begin
                        jump_flag_o <= 1'b1;
                        jump_addr_o <= target;
                        if (is_link && rd != 5'd0) begin
                            link_we_o   <= 1'b1;
                            link_rd_o   <= rd;
                            link_data_o <= ret_addr;
                        end
                        if (FLUSH_DEPTH > 0) begin
                            state <= ST_SQUASH;
                            cnt   <= CNT_LOAD;
                        end
                    end
`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
                    misalign_o <= inst_valid_i && misaligned;
`endif
                end
                ST_SQUASH: begin
                    // The PC register advances every cycle, so idle cycles
                    // count against the flush window too.
                    squash_o <= inst_valid_i;
                    cnt      <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) begin
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jump_unit.sv
// ----------------------------------------------------------------------------
// tb_jump_unit
// Self-checking bench for jump_unit (FLUSH_DEPTH=2). Instructions are built
// from a descriptor (kind, immediate, rd, funct3) by encoder functions; the
// reference model works from the descriptor directly. Directed cases pin the
// model with literal values, then a randomized run is compared every cycle.
// Honours JUMP_UNIT_MISALIGN_TRAP_EN when defined.
// ----------------------------------------------------------------------------
module tb_jump_unit;

    localparam int FD = 2;

    localparam int K_JAL  = 0;
    localparam int K_JALR = 1;
    localparam int K_BR   = 2;
    localparam int K_OTH  = 3;

`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic        inst_valid_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        squash_o;
    logic        link_we_o;
    logic [4:0]  link_rd_o;
    logic [31:0] link_data_o;
    logic        mis_out;

    jump_unit #(.FLUSH_DEPTH(FD)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .inst_valid_i (inst_valid_i),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .rs1_data_i   (rs1_data_i),
        .rs2_data_i   (rs2_data_i),
        .jump_flag_o  (jump_flag_o),
        .jump_addr_o  (jump_addr_o),
        .squash_o     (squash_o),
        .link_we_o    (link_we_o),
        .link_rd_o    (link_rd_o),
        .link_data_o  (link_data_o)
`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
        ,
        .misalign_o   (mis_out)
`endif
    );

`ifndef JUMP_UNIT_MISALIGN_TRAP_EN
    assign mis_out = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Descriptor of the instruction currently on the inputs.
    int          cur_kind = K_OTH;
    int          cur_imm  = 0;
    logic [4:0]  cur_rd   = '0;
    logic [2:0]  cur_f3   = '0;

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_j(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_i(input int imm, input logic [4:0] rd);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'($urandom), 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input logic [2:0] f3);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'($urandom), 5'($urandom), f3, v[4:1], v[11], 7'b1100011};
    endfunction

    // ---------------- reference model ----------------
    logic        exp_jump  = 1'b0;
    logic [31:0] exp_addr  = '0;
    logic        exp_sq    = 1'b0;
    logic        exp_lwe   = 1'b0;
    logic [4:0]  exp_rd    = '0;
    logic [31:0] exp_ldata = '0;
    logic        exp_mis   = 1'b0;
    int          squash_left = 0;

    function automatic bit branch_holds(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            exp_jump = 0; exp_addr = 0; exp_sq = 0; exp_lwe = 0;
            exp_rd = 0; exp_ldata = 0; exp_mis = 0; squash_left = 0;
        end else begin
            bit          tk;
            bit          lnk;
            logic [31:0] tgt;
            exp_jump = 0; exp_sq = 0; exp_lwe = 0; exp_mis = 0;
            if (squash_left > 0) begin
                exp_sq = inst_valid_i;
                squash_left--;
            end else if (inst_valid_i) begin
                tk = 0; lnk = 0; tgt = 0;
                case (cur_kind)
                    K_JAL:  begin tk = 1; lnk = 1; tgt = pc_i + 32'(cur_imm); end
                    K_JALR: begin tk = 1; lnk = 1; tgt = (rs1_data_i + 32'(cur_imm)) & 32'hFFFF_FFFE; end
                    K_BR:   begin tk = branch_holds(cur_f3, rs1_data_i, rs2_data_i); tgt = pc_i + 32'(cur_imm); end
                    default: ;
                endcase
                if (tk) begin
                    if (MIS_EN && (tgt % 4) != 0) begin
                        exp_mis = 1;
                    end else begin
                        exp_jump = 1;
                        exp_addr = tgt;
                        if (lnk && cur_rd != 0) begin
                            exp_lwe   = 1;
                            exp_rd    = cur_rd;
                            exp_ldata = pc_i + 32'd4;
                        end
                        squash_left = FD;
                    end
                end
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        check("jump_flag", 32'(jump_flag_o), 32'(exp_jump));
        check("jump_addr", jump_addr_o, exp_addr);
        check("squash", 32'(squash_o), 32'(exp_sq));
        check("link_we", 32'(link_we_o), 32'(exp_lwe));
        if (exp_lwe) begin
            check("link_rd", 32'(link_rd_o), 32'(exp_rd));
            check("link_data", link_data_o, exp_ldata);
        end
        check("misalign", 32'(mis_out), 32'(exp_mis));
    end

    // ---------------- stimulus ----------------
    // Called just after a negedge; returns at the next negedge, when the
    // outputs for this instruction are visible.
    task automatic step(input logic v, input logic [31:0] pc, input int kind, input int imm,
                        input logic [4:0] rd, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b);
        inst_valid_i = v;
        pc_i         = pc;
        rs1_data_i   = a;
        rs2_data_i   = b;
        cur_kind     = kind;
        cur_imm      = imm;
        cur_rd       = rd;
        cur_f3       = f3;
        case (kind)
            K_JAL:   inst_i = enc_j(imm, rd);
            K_JALR:  inst_i = enc_i(imm, rd);
            K_BR:    inst_i = enc_b(imm, f3);
            default: inst_i = {$urandom_range(0, 33554431), 7'b0010011};
        endcase
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, K_OTH, 0, 5'd0, 3'd0, 32'h0, 32'h0);
    endtask

    initial begin
        #1 rst_ = 1'b0;
        @(negedge clk);

        // Reset held with a valid JAL on the inputs.
        step(1'b1, 32'h100, K_JAL, 32'h20, 5'd1, 3'd0, 32'h0, 32'h0);
        step(1'b1, 32'h100, K_JAL, 32'h20, 5'd1, 3'd0, 32'h0, 32'h0);
        check("rst_jump_flag", 32'(jump_flag_o), 32'h0);
        check("rst_jump_addr", jump_addr_o, 32'h0);
        check("rst_link_we", 32'(link_we_o), 32'h0);
        check("rst_link_data", link_data_o, 32'h0);
        inst_valid_i = 1'b0;
        rst_ = 1'b1;

        // JAL pc=0x100 imm=+0x20 rd=1, then two squashed valid instructions.
        step(1'b1, 32'h100, K_JAL, 32'h20, 5'd1, 3'd0, 32'h0, 32'h0);
        check("jal_flag", 32'(jump_flag_o), 32'h1);
        check("jal_addr", jump_addr_o, 32'h120);
        check("jal_link_we", 32'(link_we_o), 32'h1);
        check("jal_link_rd", 32'(link_rd_o), 32'h1);
        check("jal_link_data", link_data_o, 32'h104);
        step(1'b1, 32'h120, K_JAL, 32'h40, 5'd3, 3'd0, 32'h0, 32'h0);
        check("sq1_squash", 32'(squash_o), 32'h1);
        check("sq1_flag", 32'(jump_flag_o), 32'h0);
        step(1'b1, 32'h124, K_BR, 16, 5'd0, 3'd0, 32'h7, 32'h7);
        check("sq2_squash", 32'(squash_o), 32'h1);
        check("sq2_link_we", 32'(link_we_o), 32'h0);
        step(1'b1, 32'h128, K_OTH, 0, 5'd0, 3'd0, 32'h0, 32'h0);
        check("sq_end", 32'(squash_o), 32'h0);

        // BEQ taken backwards, then BNE with the same operands.
        step(1'b1, 32'h200, K_BR, -8, 5'd0, 3'b000, 32'd5, 32'd5);
        check("beq_addr", jump_addr_o, 32'h1F8);
        check("beq_link_we", 32'(link_we_o), 32'h0);
        idle(FD);
        step(1'b1, 32'h200, K_BR, -8, 5'd0, 3'b001, 32'd5, 32'd5);
        check("bne_flag", 32'(jump_flag_o), 32'h0);
        check("bne_squash", 32'(squash_o), 32'h0);

        // Signed / unsigned compares with rs1=-1, rs2=1.
        step(1'b1, 32'h300, K_BR, 16, 5'd0, 3'b100, 32'hFFFF_FFFF, 32'h1);
        check("blt_flag", 32'(jump_flag_o), 32'h1);
        check("blt_addr", jump_addr_o, 32'h310);
        idle(FD);
        step(1'b1, 32'h300, K_BR, 16, 5'd0, 3'b110, 32'hFFFF_FFFF, 32'h1);
        check("bltu_flag", 32'(jump_flag_o), 32'h0);
        step(1'b1, 32'h300, K_BR, 16, 5'd0, 3'b111, 32'hFFFF_FFFF, 32'h1);
        check("bgeu_flag", 32'(jump_flag_o), 32'h1);
        idle(FD);
        step(1'b1, 32'h300, K_BR, 16, 5'd0, 3'b010, 32'hFFFF_FFFF, 32'h1);
        check("f3_010_flag", 32'(jump_flag_o), 32'h0);

        // Address wrap, rd=0.
        step(1'b1, 32'hFFFF_FFFC, K_JAL, 8, 5'd0, 3'd0, 32'h0, 32'h0);
        check("wrap_addr", jump_addr_o, 32'h4);
        check("wrap_link_we", 32'(link_we_o), 32'h0);
        idle(FD);

        // JALR to an odd base.
        step(1'b1, 32'h500, K_JALR, 0, 5'd5, 3'd0, 32'hDEAD_BEEF, 32'h0);
`ifdef JUMP_UNIT_MISALIGN_TRAP_EN
        check("jalr_mis", 32'(mis_out), 32'h1);
        check("jalr_mis_flag", 32'(jump_flag_o), 32'h0);
        step(1'b1, 32'h504, K_OTH, 0, 5'd0, 3'd0, 32'h0, 32'h0);
        check("jalr_mis_nosq", 32'(squash_o), 32'h0);
`else
        check("jalr_addr", jump_addr_o, 32'hDEAD_BEEE);
        check("jalr_link_data", link_data_o, 32'h504);
        idle(FD);
`endif

        // Reset asserted mid-squash.
        step(1'b1, 32'h600, K_JAL, 32'h100, 5'd1, 3'd0, 32'h0, 32'h0);
        step(1'b1, 32'h700, K_OTH, 0, 5'd0, 3'd0, 32'h0, 32'h0);
        check("pre_rst_squash", 32'(squash_o), 32'h1);
        #2 rst_ = 1'b0;
        #1;
        check("async_rst_squash", 32'(squash_o), 32'h0);
        @(negedge clk);
        rst_ = 1'b1;
        step(1'b1, 32'h400, K_JAL, 4, 5'd2, 3'd0, 32'h0, 32'h0);
        check("post_rst_flag", 32'(jump_flag_o), 32'h1);
        check("post_rst_addr", jump_addr_o, 32'h404);
        idle(FD);

        // Randomized run.
        for (int i = 0; i < 3000; i++) begin
            logic        v;
            int          kind;
            int          imm;
            logic [31:0] pc;
            logic [31:0] a;
            logic [31:0] b;
            v    = ($urandom_range(0, 3) != 0);
            kind = $urandom_range(0, 3);
            pc   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                               : ($urandom & 32'hFFFF_FFFC);
            a    = $urandom;
            b    = ($urandom_range(0, 3) == 0) ? a : $urandom;
            case (kind)
                K_JAL:   imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
                K_JALR:  imm = int'($urandom_range(0, 4095)) - 2048;
                K_BR:    imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
                default: imm = 0;
            endcase
            step(v, pc, kind, imm, 5'($urandom), 3'($urandom), a, b);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
